// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one saturating down-counter among REQ requesters.
// Each grant loads the winner's duration, counts to zero and pulses that winner's done line.
module timer_arbiter #(
  parameter int unsigned N   = 6,
  parameter int unsigned REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ-1:0]   req,
  input  logic [REQ*N-1:0] duration,
  input  logic             pause,
  output logic [REQ-1:0]   grant,
  output logic             busy,
  output logic [N-1:0]     count,
  output logic [REQ-1:0]   done
);

  localparam int unsigned IW = (REQ > 1) ? $clog2(REQ) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [REQ-1:0] grant_q, grant_d;
  logic [N-1:0]   count_q, count_d;
  logic [N-1:0]   dur_q, dur_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  win_q, win_d;

  logic [N-1:0]   dur_arr [REQ];
  logic [IW-1:0]  pick;
  logic [IW-1:0]  idx;
  logic           found;
  logic [IW-1:0]  win_next;

  for (genvar i = 0; i < REQ; i++) begin : g_dur
    assign dur_arr[i] = duration[i*N +: N];
  end

  // First requester at or above the pointer, wrapping modulo REQ.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < REQ; k++) begin
      idx = IW'((32'(ptr_q) + k) % REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign win_next = (win_q == IW'(REQ - 1)) ? '0 : win_q + IW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    count_d = count_q;
    dur_d   = dur_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = REQ'(1) << pick;
          win_d   = pick;
          dur_d   = dur_arr[pick];
          state_d = StLoad;
        end
      end
      StLoad: begin
        count_d = dur_q;
        state_d = StRun;
      end
      StRun: begin
        // Abort wins over pause and zero-detect; the count is left where it stopped.
        if (!req[win_q]) begin
          grant_d = '0;
          ptr_d   = win_next;
          state_d = StIdle;
        end else if (pause) begin
          state_d = StRun;
        end else if (count_q == '0) begin
          state_d = StDone;
        end else begin
          count_d = count_q - N'(1);
        end
      end
      StDone: begin
        grant_d = '0;
        ptr_d   = win_next;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      count_q <= '0;
      dur_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      count_q <= count_d;
      dur_q   <= dur_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != StIdle);
  assign count = count_q;
  assign done  = (state_q == StDone) ? grant_q : '0;

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
Round-robin scheduler that shares one N-bit down-counter among REQ requesters, each asking for a timed interval.
- Grants one requester at a time and loads that requester's duration.
- Counts down to zero without wrap-around, then pulses that requester's done line.
- Sits between the control FSMs that need delays and the shared countdown datapath.

Parameters:
N, 6, counter/duration width in bits
REQ, 4, number of requesters (≥2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
req  input  REQ  level request per requester; must stay high until done or it aborts
duration  input  REQ*N  packed durations; slice i = duration[i*N +: N], sampled at grant
pause  input  1  freezes counting while high (RUN state only)
grant  output  REQ  one-hot owner of the counter, all-zero when idle
busy  output  1  high in LOAD, RUN, DONE
count  output  N  current counter value
done  output  REQ  one-cycle completion pulse, one-hot, on granted index

Behaviour:
- Reset (async, immediate): state=IDLE, grant=0, count=0, rr pointer=0, latched duration=0, busy=0, done=0. Reset asserted mid-run aborts silently; no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE. All outputs come from registers or decode of state/grant; no combinational path from req or pause to outputs.
- IDLE:
  - If req==0, stay.
  - Else pick the winner: first set bit of req searching from pointer upward, wrapping modulo REQ.
  - At the edge: grant<=onehot(winner), latch duration slice of winner, state<=LOAD.
- LOAD: count<=latched duration; state<=RUN. pause is ignored.
- RUN:
  - If req[winner]==0: abort. grant<=0, pointer<=winner+1 mod REQ, state<=IDLE, no done. Abort has priority over pause and zero-detect.
  - Else if pause: hold count and state.
  - Else if count==0: state<=DONE.
  - Else count<=count-1.
- DONE:
  - done=grant for this single cycle.
  - At the edge: grant<=0, pointer<=winner+1 mod REQ, state<=IDLE. count holds 0.
- Never wraps: count stops at 0. 0 is never followed by all-ones.
- Timing, request seen in IDLE at edge t, no pause:
  - LOAD in cycle t+1.
  - RUN for D+1 cycles with count = D, D-1, …, 0.
  - done pulse in cycle t+3+D.
  - Earliest next grant: IDLE cycle t+4+D, granted at the following edge.
- D=0: one RUN cycle with count 0, then DONE.
- D=2^N-1: full-range countdown, no overflow.
- New requests arriving while busy are not granted until IDLE. req changes of non-winners during RUN are ignored.
- busy = (state!=IDLE). grant is stable (constant) from LOAD through DONE.

Test Plan:
1. Reset, then req=0001, duration[0]=3, pause=0 → grant=0001 one cycle after req is seen; count sequence 3,2,1,0; done=0001 for exactly one cycle, 6 cycles after req is sampled; busy low afterwards.
2. req=1111 held, all durations=1 → grants in order 0001, 0010, 0100, 1000, 0001; each done pulse on the matching bit; no requester skipped.
3. req=0010, D=5; pause high for 3 cycles while count=3 → count holds 3 for 3 cycles, done arrives 3 cycles later than unpaused; D=0 case gives done 3 cycles after req is sampled.
4. req=0100, D=10; drop req[2] when count=6 → next edge grant=0, busy=0, no done pulse; pointer advances so req=0101 then grants 0001 last... correction: pointer=3, so req=0101 grants 0001 (wrap search 3,0).
5. D=63 (N=6): count reaches 0 and DONE follows; count never shows 63 after 0, no wrap.
6. Assert rst asynchronously mid-RUN (between edges) → grant, busy, count, done go to 0 immediately; after release, req=1000 is granted with pointer=0 search order.
